// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI4-Lite response codes and bridge state encoding
package axi_lite_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR_DATA,
      WR_RESP,
      RD_ADDR,
      RD_DATA,
      DONE,
      DRAIN
   } state_t;

endpackage

// File: rtl/axi_lite_master_bridge.sv
// axi_lite_master_bridge: simple command port (transfer/write/addr/wdata/wstrb -> ready/rdata/resp/timeout)
// driving the AW/W/B/AR/R channels of an AXI4-Lite slave; a watchdog forces a SLVERR completion and the
// bridge then drains the late handshakes of the aborted command before accepting new ones.
module axi_lite_master_bridge
   import axi_lite_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 256
)(
   input  logic                ACLK,
   input  logic                ARESETn,
   input  logic                transfer,
   input  logic                write,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   output logic                ready,
   output logic [DATA_W-1:0]   rdata,
   output logic [1:0]          resp,
   output logic                timeout,
   output logic [ADDR_W-1:0]   AWADDR,
   output logic                AWVALID,
   input  logic                AWREADY,
   output logic [DATA_W-1:0]   WDATA,
   output logic [DATA_W/8-1:0] WSTRB,
   output logic                WVALID,
   input  logic                WREADY,
   input  logic [1:0]          BRESP,
   input  logic                BVALID,
   output logic                BREADY,
   output logic [ADDR_W-1:0]   ARADDR,
   output logic                ARVALID,
   input  logic                ARREADY,
   input  logic [DATA_W-1:0]   RDATA,
   input  logic [1:0]          RRESP,
   input  logic                RVALID,
   output logic                RREADY
);

   localparam int CW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;

   state_t              state, state_n;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q, rdata_q;
   logic [DATA_W/8-1:0] wstrb_q;
   logic [1:0]          resp_q;
   logic [CW-1:0]       cnt;
   logic                awv, wv, arv, bpend, rpend, to_q;
   logic                busy, expire, tmo, issue;

   assign issue  = state == IDLE && transfer;
   assign busy   = state inside {WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA};
   assign expire = TIMEOUT_CYC != 0 && busy && cnt == CW'(TIMEOUT_CYC - 1);
   // a response arriving on the expiry cycle completes normally
   assign tmo    = expire && !(state == WR_RESP && BVALID) && !(state == RD_DATA && RVALID);

   assign AWADDR  = addr_q;
   assign ARADDR  = addr_q;
   assign WDATA   = wdata_q;
   assign WSTRB   = wstrb_q;
   assign AWVALID = awv;
   assign WVALID  = wv;
   assign ARVALID = arv;
   // in DRAIN the outstanding response is still accepted, then dropped
   assign BREADY  = state == WR_RESP || (state == DRAIN && bpend);
   assign RREADY  = state == RD_DATA || (state == DRAIN && rpend);
   assign ready   = state == DONE || tmo;
   assign timeout = tmo || to_q;
   assign resp    = tmo ? SLVERR : resp_q;
   assign rdata   = tmo ? '0 : rdata_q;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:         state_n = transfer ? (write ? WR_ADDR_DATA : RD_ADDR) : IDLE;
         WR_ADDR_DATA: state_n = tmo ? DRAIN : ((!awv || AWREADY) && (!wv || WREADY)) ? WR_RESP : WR_ADDR_DATA;
         WR_RESP:      state_n = BVALID ? DONE : tmo ? DRAIN : WR_RESP;
         RD_ADDR:      state_n = tmo ? DRAIN : ARREADY ? RD_DATA : RD_ADDR;
         RD_DATA:      state_n = RVALID ? DONE : tmo ? DRAIN : RD_DATA;
         DONE:         state_n = IDLE;
         DRAIN:        state_n = (awv || wv || arv || bpend || rpend) ? DRAIN : IDLE;
         default:      state_n = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
         resp_q  <= '0;
         cnt     <= '0;
         awv     <= 1'b0;
         wv      <= 1'b0;
         arv     <= 1'b0;
         bpend   <= 1'b0;
         rpend   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state <= state_n;
         // each channel tracks its own handshake so AW and W may finish in either order
         awv   <= issue ? write  : awv & ~AWREADY;
         wv    <= issue ? write  : wv & ~WREADY;
         arv   <= issue ? ~write : arv & ~ARREADY;
         bpend <= issue ? write  : bpend & ~(BVALID & BREADY);
         rpend <= issue ? ~write : rpend & ~(RVALID & RREADY);
         cnt   <= busy ? cnt + 1'b1 : '0;
         to_q  <= tmo | (to_q & (state_n != DONE));
         if (issue) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
         end
         if (tmo) begin
            resp_q  <= SLVERR;
            rdata_q <= '0;
         end else if (state_n == DONE) begin
            resp_q <= state == WR_RESP ? BRESP : RRESP;
            if (state == RD_DATA) rdata_q <= RDATA;
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// tb_axi_lite_master_bridge: scoreboard bench with a delay-configurable AXI4-Lite memory slave
module tb_axi_lite_master_bridge;
   import axi_lite_pkg::*;

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  resp;
      logic        to;
      logic        rd;
   } exp_t;

   logic        clk, ARESETn;
   logic        transfer, write, ready, timeout;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  resp;
   logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
   logic [3:0]  WSTRB;
   logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
   logic [1:0]  BRESP, RRESP;

   int   vec = 0, err = 0;
   exp_t sb[$];
   logic [31:0] ref_mem [16] = '{default: 32'h0};
   logic [31:0] mem [16] = '{default: 32'h0};

   int aw_delay, w_delay, aw_cnt, w_cnt;
   int n_aw = 0, n_w = 0, n_b = 0, unstable = 0, bready_early = 0;
   logic ar_block;
   logic [1:0] rresp_cfg;
   logic aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_done, w_done, ar_done, awv_p, wv_p, arv_p;
   logic [31:0] aw_cap, w_cap, ar_cap, awaddr_p, wdata_p, araddr_p;
   logic [3:0]  ws_cap, wstrb_p;

   axi_lite_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
      .ACLK(clk), .ARESETn(ARESETn),
      .transfer(transfer), .write(write), .addr(addr), .wdata(wdata), .wstrb(wstrb),
      .ready(ready), .rdata(rdata), .resp(resp), .timeout(timeout),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec++;
      if (got !== exp) begin
         err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // slave: READY/VALID decisions made on the falling edge, handshakes land on the next rising edge
   always @(negedge clk) begin
      if (!ARESETn) begin
         AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
         BRESP = 0; RRESP = 0; RDATA = 0; aw_cnt = 0; w_cnt = 0;
         {aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_done, w_done, ar_done, awv_p, wv_p, arv_p} = '0;
      end else begin
         if (awv_p && !aw_hs && (!AWVALID || AWADDR !== awaddr_p)) unstable++;
         if (wv_p && !w_hs && (!WVALID || WDATA !== wdata_p || WSTRB !== wstrb_p)) unstable++;
         if (arv_p && !ar_hs && (!ARVALID || ARADDR !== araddr_p)) unstable++;
         if (aw_hs) begin aw_done = 1; n_aw++; end
         if (w_hs) begin w_done = 1; n_w++; end
         if (ar_hs) ar_done = 1;
         if (b_hs) begin BVALID = 0; n_b++; end
         if (r_hs) RVALID = 0;
         if (aw_done && w_done && !BVALID) begin
            for (int i = 0; i < 4; i++) if (ws_cap[i]) mem[aw_cap[5:2]][i*8 +: 8] = w_cap[i*8 +: 8];
            BVALID = 1; BRESP = OKAY; aw_done = 0; w_done = 0;
         end
         if (ar_done && !RVALID) begin
            RVALID = 1; RDATA = mem[ar_cap[5:2]]; RRESP = rresp_cfg; ar_done = 0;
         end
         if (BREADY && (n_aw != n_b + 1 || n_w != n_b + 1)) bready_early++;
         AWREADY = AWVALID && aw_cnt >= aw_delay;
         aw_cnt  = AWVALID ? aw_cnt + 1 : 0;
         WREADY  = WVALID && w_cnt >= w_delay;
         w_cnt   = WVALID ? w_cnt + 1 : 0;
         ARREADY = ARVALID && !ar_block;
         aw_hs = AWVALID && AWREADY; if (aw_hs) aw_cap = AWADDR;
         w_hs  = WVALID && WREADY;   if (w_hs) begin w_cap = WDATA; ws_cap = WSTRB; end
         ar_hs = ARVALID && ARREADY; if (ar_hs) ar_cap = ARADDR;
         b_hs  = BVALID && BREADY;
         r_hs  = RVALID && RREADY;
         awv_p = AWVALID; awaddr_p = AWADDR;
         wv_p  = WVALID;  wdata_p = WDATA; wstrb_p = WSTRB;
         arv_p = ARVALID; araddr_p = ARADDR;
      end
   end

   always @(negedge clk) begin
      if (ARESETn && ready) begin
         if (sb.size() == 0) chk("spurious_ready", ready, 0);
         else begin
            exp_t e;
            e = sb.pop_front();
            if (e.rd) chk("rdata", rdata, e.rdata);
            chk("resp", resp, e.resp);
            chk("timeout", timeout, e.to);
         end
      end
   end

   // lat counts the cycle in which transfer is sampled as cycle 1
   task automatic do_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [1:0] eresp, input logic eto, output int lat);
      exp_t e;
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{s[i]}};
      e.rdata = eto ? 32'h0 : ref_mem[a[5:2]];
      e.resp  = eto ? SLVERR : eresp;
      e.to    = eto;
      e.rd    = !wr || eto;
      if (wr && !eto) ref_mem[a[5:2]] = (ref_mem[a[5:2]] & ~m) | (d & m);
      sb.push_back(e);
      transfer = 1; write = wr; addr = a; wdata = d; wstrb = s;
      lat = 1;
      do begin @(negedge clk); lat++; end while (!ready && lat < 300);
      chk("ready_seen", ready, 1);
      transfer = 0;
      @(negedge clk);
      chk("ready_1cyc", ready, 0);
   endtask

   initial begin
      int lat;
      ARESETn = 0; transfer = 0; write = 0; addr = 0; wdata = 0; wstrb = 0;
      aw_delay = 0; w_delay = 0; ar_block = 0; rresp_cfg = OKAY;
      repeat (3) @(negedge clk);
      chk("rst_awvalid", AWVALID, 0);
      chk("rst_wvalid", WVALID, 0);
      chk("rst_arvalid", ARVALID, 0);
      chk("rst_bready", BREADY, 0);
      chk("rst_rready", RREADY, 0);
      chk("rst_ready", ready, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_resp", resp, 0);
      chk("rst_rdata", rdata, 0);
      #2 ARESETn = 1;
      @(negedge clk);

      do_cmd(1, 32'h0, 32'hDEEDBEEF, 4'hF, OKAY, 0, lat);
      chk("wr_lat", lat, 4);
      chk("awaddr", aw_cap, 32'h0);
      chk("wdata", w_cap, 32'hDEEDBEEF);
      chk("wstrb", ws_cap, 4'hF);

      aw_delay = 0; w_delay = 3;
      do_cmd(1, 32'h8, 32'h11112222, 4'hF, OKAY, 0, lat);
      aw_delay = 3; w_delay = 0;
      do_cmd(1, 32'h8, 32'h33334444, 4'hC, OKAY, 0, lat);
      aw_delay = 1; w_delay = 1;
      do_cmd(1, 32'h8, 32'h5555AAAA, 4'h6, OKAY, 0, lat);
      aw_delay = 0; w_delay = 0;
      chk("n_aw", n_aw, 4);
      chk("n_w", n_w, 4);
      chk("n_b", n_b, 4);
      do_cmd(0, 32'h8, 32'h0, 4'h0, OKAY, 0, lat);

      do_cmd(1, 32'h4, 32'hDEEDBEE0, 4'h3, OKAY, 0, lat);
      do_cmd(0, 32'h4, 32'h0, 4'h0, OKAY, 0, lat);
      chk("rd_lat", lat, 4);

      do_cmd(1, 32'hC, 32'hCAFEF00D, 4'hF, OKAY, 0, lat);
      rresp_cfg = DECERR;
      do_cmd(0, 32'hC, 32'h0, 4'h0, DECERR, 0, lat);
      rresp_cfg = OKAY;
      chk("valid_stable", unstable, 0);
      chk("bready_order", bready_early, 0);

      ar_block = 1;
      do_cmd(0, 32'h8, 32'h0, 4'h0, SLVERR, 1, lat);
      chk("to_cycles", lat - 1, 16);
      transfer = 1; write = 1; addr = 32'h20; wdata = 32'h99999999; wstrb = 4'hF;
      repeat (5) @(negedge clk);
      chk("drain_no_aw", AWVALID, 0);
      chk("drain_arv_held", ARVALID, 1);
      chk("to_hold", timeout, 1);
      chk("resp_hold", resp, SLVERR);
      transfer = 0;
      ar_block = 0;
      repeat (8) @(negedge clk);
      chk("drain_arv_done", ARVALID, 0);
      chk("drain_aw_idle", AWVALID, 0);
      do_cmd(0, 32'h0, 32'h0, 4'h0, OKAY, 0, lat);
      chk("post_drain_lat", lat, 4);

      aw_delay = 10; w_delay = 10;
      transfer = 1; write = 1; addr = 32'h10; wdata = 32'h77777777; wstrb = 4'hF;
      @(negedge clk);
      transfer = 0;
      @(negedge clk);
      chk("awv_before_rst", AWVALID, 1);
      #2 ARESETn = 0;
      #1;
      chk("rst_awv_async", AWVALID, 0);
      chk("rst_wv_async", WVALID, 0);
      repeat (3) @(negedge clk);
      chk("rst_no_ready", ready, 0);
      #2 ARESETn = 1;
      aw_delay = 0; w_delay = 0;
      @(negedge clk);
      do_cmd(1, 32'h10, 32'h55AA55AA, 4'hF, OKAY, 0, lat);
      chk("post_rst_lat", lat, 4);
      do_cmd(0, 32'h10, 32'h0, 4'h0, OKAY, 0, lat);
      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule

// File: doc/axi_lite_master_bridge.md
Name: axi_lite_master_bridge

Overview:
- Parametrised AXI4-Lite master.
- Converts the team's simple command port (transfer/write/addr/wdata → ready/rdata) into the five AXI4-Lite channels.
- Successor to the fixed 32-bit master. Adds:
  - ADDR_W/DATA_W generalisation
  - byte strobes
  - AW/W handshakes completing in either order
  - response-code reporting
  - watchdog timeout with safe drain of late responses
- Sits between a CPU/test driver and any AXI4-Lite slave or interconnect.

Parameters:
ADDR_W, 32, address width (≥ 2)
DATA_W, 32, data width (32 or 64)
TIMEOUT_CYC, 256, cycles from issue to forced completion; 0 disables watchdog

Ports:
ACLK  in  1  clock, rising edge
ARESETn  in  1  asynchronous active-low reset
transfer  in  1  command request; held high until ready
write  in  1  1 = write, 0 = read; sampled with transfer
addr  in  ADDR_W  byte address
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  byte enables for write
ready  out  1  one-cycle completion pulse
rdata  out  DATA_W  read data, valid with ready
resp  out  2  AXI response of completed command (valid with ready)
timeout  out  1  completion was forced by watchdog (valid with ready)
AWADDR  out  ADDR_W;  AWVALID  out  1;  AWREADY  in  1
WDATA  out  DATA_W;  WSTRB  out  DATA_W/8;  WVALID  out  1;  WREADY  in  1
BRESP  in  2;  BVALID  in  1;  BREADY  out  1
ARADDR  out  ADDR_W;  ARVALID  out  1;  ARREADY  in  1
RDATA  in  DATA_W;  RRESP  in  2;  RVALID  in  1;  RREADY  out  1

Behaviour:
- Reset (async, ARESETn=0):
  - All VALID/READY outputs, ready and timeout are 0.
  - rdata, resp, address and data registers are 0.
  - State = IDLE; watchdog counter = 0.
- IDLE: on transfer=1, latch addr/wdata/wstrb/write.
  - write=1 → WR_ADDR_DATA, with AWVALID=WVALID=1 from the next cycle.
  - write=0 → RD_ADDR, with ARVALID=1 from the next cycle.
- WR_ADDR_DATA: AWVALID and WVALID are each cleared on their own handshake (VALID&READY), independently.
  - Either order is legal; both in the same cycle is legal.
  - When both are done → WR_RESP with BREADY=1.
- WR_RESP: on BVALID, capture BRESP into resp → DONE.
- RD_ADDR: ARVALID held until ARREADY → RD_DATA with RREADY=1.
- RD_DATA: on RVALID, capture RDATA into rdata and RRESP into resp → DONE.
- DONE: ready=1 for exactly one cycle → IDLE.
  - A transfer still high in the following IDLE cycle is a new command; drivers drop transfer on ready.
- AXI rules:
  - VALID never deasserts before its handshake.
  - Address, data and strobe outputs are stable while their VALID is high.
  - The bridge never waits on READY before asserting VALID.
- Minimum latency (slave always ready): write = 4 cycles, read = 4 cycles from transfer sampled to ready.
- Watchdog (TIMEOUT_CYC>0):
  - Counter clears on leaving IDLE and increments every cycle in any non-IDLE, non-DONE, non-DRAIN state.
  - At count == TIMEOUT_CYC−1: ready=1, timeout=1, resp=SLVERR, rdata=0.
  - The bridge then enters DRAIN instead of IDLE.
- DRAIN:
  - Outstanding VALIDs stay asserted until their handshakes complete.
  - BREADY/RREADY stay 1 to absorb the late response, which is discarded.
  - Return to IDLE only when every channel of the aborted command has completed.
  - New transfers are ignored (not latched) in DRAIN.
- Response in the same cycle as watchdog expiry: the response wins; normal completion, timeout=0.
- Reset mid-transaction: all VALIDs drop immediately; no completion pulse.
- resp and timeout hold their value until the next completion.

Decomposition:
- axi_lite_pkg holds:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11
  - bridge state enum: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE, DRAIN
- Single module; the watchdog counter is inline. No sub-module is warranted.

Test Plan:
- Slave always ready; write 0x0 ← 0xDEEDBEEF, wstrb=0xF → AWADDR=0x0, WDATA=0xDEEDBEEF, WSTRB=0xF; ready 4 cycles after transfer; resp=OKAY; timeout=0.
- Slave delays WREADY 3 cycles after AWREADY, then the reverse order, then a same-cycle handshake → each completes once; BREADY asserts only after both handshakes; VALIDs stable while waiting.
- Write 0x4 ← 0xDEEDBEE0 with wstrb=0x3, then read 0x4 from a memory-model slave → rdata=0x0000BEE0; resp=OKAY.
- Read 0xC with the slave returning RRESP=DECERR → ready pulse with resp=2'b11; rdata = slave RDATA.
- TIMEOUT_CYC=16, slave never asserts ARREADY → ready at cycle 16 with timeout=1, resp=SLVERR, rdata=0. Bridge is in DRAIN, and a new transfer is ignored. Slave then completes AR/R → bridge returns to IDLE and the next read of 0x0 succeeds normally.
- ARESETn pulsed low while AWVALID=1 → AWVALID/WVALID drop asynchronously; no ready pulse; first command after reset completes normally.
